// File: rtl/led_pwm_duty_decoder_pkg.sv
// Shared LED driver constants and the decoder state encoding.
// Not a datapath; adds no latency and applies no backpressure.
package led_pwm_duty_decoder_pkg;

  localparam int PWM_PERIOD = 16;
  localparam int LED_LVL_W  = 4;
  localparam int LVL_MAX    = (1 << LED_LVL_W) - 1;

  typedef enum logic {
    HUNT = 1'b0,
    MEAS = 1'b1
  } dec_state_t;

endpackage

// File: rtl/led_pwm_duty_decoder_sync_rise_det.sv
// Two-flop synchroniser with a delay stage and a rising-edge pulse.
// Synchronised level is two clocks behind the input; no backpressure.
module led_pwm_duty_decoder_sync_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign dout = s2;
  assign rise = s2 & ~s3;

endmodule

// File: rtl/led_pwm_duty_decoder.sv
// Recovers the brightness level from a looped-back PWM line, one strobe per frame or timeout.
// Strobes appear 3 clocks after the closing input edge; free-running, no backpressure.
module led_pwm_duty_decoder
  import led_pwm_duty_decoder_pkg::*;
#(
  parameter int PERIOD  = PWM_PERIOD,
  parameter int LVL_W   = LED_LVL_W,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic [LVL_W-1:0] level,
  output logic             level_valid,
  output logic             period_err,
  output logic             locked
);

  localparam int                CNT_W    = LVL_W + 1;
  localparam int                TMO_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  PER_C    = CNT_W'(PERIOD);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [LVL_W-1:0]  LVL_TOP  = '1;

  logic             s2;
  logic             rise;
  dec_state_t       state, state_nxt;
  logic [CNT_W-1:0] per_cnt, per_nxt;
  logic [CNT_W-1:0] hi_cnt, hi_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic             valid_nxt;
  logic             err_nxt;
  logic             locked_nxt;

  led_pwm_duty_decoder_sync_rise_det u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (pwm_in),
    .dout  (s2),
    .rise  (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      per_cnt     <= '0;
      hi_cnt      <= '0;
      tmo_cnt     <= '0;
      level       <= '0;
      level_valid <= 1'b0;
      period_err  <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= state_nxt;
      per_cnt     <= per_nxt;
      hi_cnt      <= hi_nxt;
      tmo_cnt     <= tmo_nxt;
      level       <= level_nxt;
      level_valid <= valid_nxt;
      period_err  <= err_nxt;
      locked      <= locked_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    per_nxt    = per_cnt;
    hi_nxt     = hi_cnt;
    tmo_nxt    = tmo_cnt;
    level_nxt  = level;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    locked_nxt = locked;

    // The rise cycle closes the previous frame and is the first cycle of the next one.
    if (rise) begin
      if (state == MEAS) begin
        if (per_cnt == PER_C) begin
          level_nxt  = (hi_cnt > CNT_W'(LVL_TOP)) ? LVL_TOP : hi_cnt[LVL_W-1:0];
          valid_nxt  = 1'b1;
          locked_nxt = 1'b1;
        end else begin
          err_nxt    = 1'b1;
          locked_nxt = 1'b0;
        end
      end
      state_nxt = MEAS;
      per_nxt   = CNT_W'(1);
      hi_nxt    = CNT_W'(1);
      tmo_nxt   = '0;
    end else if (tmo_cnt == TMO_LAST) begin
      level_nxt  = s2 ? LVL_TOP : '0;
      valid_nxt  = 1'b1;
      locked_nxt = 1'b0;
      state_nxt  = HUNT;
      tmo_nxt    = '0;
    end else begin
      tmo_nxt = tmo_cnt + TMO_W'(1);
      if (state == MEAS) begin
        if (per_cnt != CNT_MAX) per_nxt = per_cnt + CNT_W'(1);
        if (s2 && (hi_cnt != CNT_MAX)) hi_nxt = hi_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_pwm_duty_decoder.sv
// Randomised and directed PWM frames against a frame-level reference model with a strobe scoreboard.
module tb_led_pwm_duty_decoder;
  import led_pwm_duty_decoder_pkg::*;

  localparam int PER = PWM_PERIOD;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm_in = 1'b0;
  logic [3:0] level;
  logic       level_valid;
  logic       period_err;
  logic       locked;

  led_pwm_duty_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_in      (pwm_in),
    .level       (level),
    .level_valid (level_valid),
    .period_err  (period_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit err;
    int lvl;
    bit lck;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  // Reference model: the decoder sees the input two clocks late (reset zeros first),
  // splits that stream into frames at each 0->1 transition and judges each whole frame.
  bit d1 = 0, d2 = 0, prev = 0, in_meas = 0, m_locked = 0;
  int frame_q[$];
  int since = 0;
  int m_level = 0;
  int cyc = 0;

  task automatic push_ev(input bit err, input int lvl, input bit lck);
    ev_t e;
    e.cyc = cyc; e.err = err; e.lvl = lvl; e.lck = lck;
    exp_q.push_back(e);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 = 0; d2 = 0; prev = 0; in_meas = 0; since = 0;
      m_level = 0; m_locked = 0;
      frame_q.delete();
      exp_q.delete();
    end else begin : model_step
      bit y;
      int lv;
      y = d2; d2 = d1; d1 = pwm_in;
      cyc++;
      if (y && !prev) begin
        if (in_meas) begin
          if (frame_q.size() == PER) begin
            lv = frame_q.sum();
            if (lv > LVL_MAX) lv = LVL_MAX;
            m_level = lv; m_locked = 1;
            push_ev(0, m_level, 1);
          end else begin
            m_locked = 0;
            push_ev(1, m_level, 0);
          end
        end
        frame_q.delete();
        frame_q.push_back(1);
        in_meas = 1;
        since = 0;
      end else begin
        if (in_meas) frame_q.push_back(int'(y));
        if (since == TMO - 1) begin
          m_level = y ? LVL_MAX : 0;
          m_locked = 0;
          push_ev(0, m_level, 0);
          in_meas = 0;
          frame_q.delete();
          since = 0;
        end else begin
          since++;
        end
      end
      prev = y;
    end
  end

  always @(negedge clk) begin : monitor
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      n_chk++; n_fail++;
      $display("FAIL missed_strobe: expected at cycle %0d err=%0d level=%0d, absent through cycle %0d",
               e.cyc, e.err, e.lvl, cyc);
    end
    if (level_valid || period_err) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: cycle %0d valid=%0d err=%0d level=%0d, none required",
                 cyc, level_valid, period_err, level);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || (level_valid && period_err) || period_err != e.err ||
            int'(level) != e.lvl || locked != e.lck) begin
          n_fail++;
          $display("FAIL strobe: cycle %0d got valid=%0d err=%0d level=%0d locked=%0d, need cycle %0d err=%0d level=%0d locked=%0d",
                   cyc, level_valid, period_err, level, locked, e.cyc, e.err, e.lvl, e.lck);
        end
      end
    end
    n_chk++;
    if (int'(level) != m_level || locked != m_locked) begin
      n_fail++;
      $display("FAIL held_state: cycle %0d rst_n=%0d got level=%0d locked=%0d, need level=%0d locked=%0d",
               cyc, rst_n, level, locked, m_level, m_locked);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input int hi, input int per);
    for (int i = 0; i < per; i++) begin
      pwm_in = (i < hi);
      tick();
    end
  endtask

  task automatic hold(input bit v, input int n);
    pwm_in = v;
    repeat (n) tick();
  endtask

  initial begin
    int hi;
    int per;
    // Reset held while the input toggles.
    for (int i = 0; i < 10; i++) begin
      pwm_in = i[0];
      tick();
    end
    pwm_in = 1'b0;
    rst_n = 1'b1;
    tick();

    // Steady duty 5.
    repeat (6) frame(5, PER);

    // Breathing ramp 1..15..1.
    for (int l = 1; l <= 15; l++) frame(l, PER);
    for (int l = 14; l >= 1; l--) frame(l, PER);

    // Constant low then constant high.
    hold(1'b0, 200);
    hold(1'b1, 200);

    // Wrong period, then recovery.
    repeat (4) frame(7, 20);
    repeat (3) frame(11, PER);

    // Reset in the middle of a level-9 frame.
    repeat (2) frame(9, PER);
    for (int i = 0; i < 7; i++) begin
      pwm_in = (i < 9);
      tick();
    end
    rst_n = 1'b0;
    hold(1'b0, 3);
    rst_n = 1'b1;
    repeat (3) frame(9, PER);

    // Random frames with occasional off-period lengths.
    for (int k = 0; k < 40; k++) begin
      hi  = int'($urandom_range(1, 15));
      per = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 18)) : PER;
      if (hi >= per) hi = per - 1;
      frame(hi, per);
    end

    hold(1'b0, 8);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d strobes still outstanding, need 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
